aclk_alarm_bank: RTL and testbench

//  Parametrised multi-slot alarm store with match detection for the 24-hour alarm clock. Holds
//  NUM_ALARMS BCD hh:mm alarms, each with its own enable. Validates loads and compares each slot

---
 rtl/aclk_alarm_bank.sv | 216 +++++++++++++++++++++
 tb/tb_aclk_alarm_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/aclk_alarm_bank.sv
// ---------------------------------------------------------------------------
// aclk_alarm_bank
// Multi-slot alarm store for the 24-hour alarm clock. Each slot holds a BCD
// hh:mm alarm and an enable. Each slot is compared against the running clock
// time. A slot raises a sticky pending flag once per occurrence of its time.
// Pending flags can be acknowledged, or snoozed by SNOOZE_MIN minutes.
//
// Ports
//   clock, reset              rising-edge clock, async active-low reset
//   load_new_alarm            strobe: write new_alarm_* into load_slot
//   load_slot                 target slot for load / disable
//   new_alarm_{ms,ls}_{hr,min}  BCD alarm time to load
//   disable_alarm             clear enable/pending/snooze of load_slot
//   current_time_*            running BCD clock time (assumed valid)
//   alarm_ack                 clear all pending flags, cancel snoozes
//   snooze                    re-arm pending slots SNOOZE_MIN minutes ahead
//   rd_slot                   readback select
//   alarm_time_*              stored time of rd_slot (combinational)
//   alarm_enabled             per-slot enable
//   alarm_pending             per-slot sticky fired flag
//   alarm                     OR of alarm_pending
//   load_err                  one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module aclk_alarm_bank #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SLOT_W     = 2,
  parameter int unsigned SNOOZE_MIN = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_new_alarm,
  input  logic [SLOT_W-1:0]     load_slot,
  input  logic [3:0]            new_alarm_ms_hr,
  input  logic [3:0]            new_alarm_ls_hr,
  input  logic [3:0]            new_alarm_ms_min,
  input  logic [3:0]            new_alarm_ls_min,
  input  logic                  disable_alarm,
  input  logic [3:0]            current_time_ms_hr,
  input  logic [3:0]            current_time_ls_hr,
  input  logic [3:0]            current_time_ms_min,
  input  logic [3:0]            current_time_ls_min,
  input  logic                  alarm_ack,
  input  logic                  snooze,
  input  logic [SLOT_W-1:0]     rd_slot,
  output logic [3:0]            alarm_time_ms_hr,
  output logic [3:0]            alarm_time_ls_hr,
  output logic [3:0]            alarm_time_ms_min,
  output logic [3:0]            alarm_time_ls_min,
  output logic [NUM_ALARMS-1:0] alarm_enabled,
  output logic [NUM_ALARMS-1:0] alarm_pending,
  output logic                  alarm,
  output logic                  load_err
);

  localparam int unsigned MIN_W = 7;  // holds 59 + 59
  localparam int unsigned HR_W  = 5;  // holds 24

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  // Slot state
  bcd_time_t                 time_q     [NUM_ALARMS];
  bcd_time_t                 time_d     [NUM_ALARMS];
  bcd_time_t                 snz_time_q [NUM_ALARMS];
  bcd_time_t                 snz_time_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]     en_q,      en_d;
  logic [NUM_ALARMS-1:0]     pend_q,    pend_d;
  logic [NUM_ALARMS-1:0]     snz_act_q, snz_act_d;
  logic [NUM_ALARMS-1:0]     mprev_q,   mprev_d;
  logic                      load_err_q, load_err_d;

  // Combinational helpers
  bcd_time_t                 cur_time_c;
  bcd_time_t                 new_time_c;
  bcd_time_t                 snz_calc_c;
  bcd_time_t                 target_c   [NUM_ALARMS];
  bcd_time_t                 rd_time_c;
  logic [NUM_ALARMS-1:0]     match_c;
  logic [NUM_ALARMS-1:0]     fire_c;
  logic                      hr_ok_c;
  logic                      slot_ok_c;
  logic                      load_valid_c;
  logic                      snooze_go_c;
  logic                      ack_go_c;
  logic [MIN_W-1:0]          cur_min_bin_c, snz_min_bin_c;
  logic [HR_W-1:0]           cur_hr_bin_c,  snz_hr_bin_c;

  assign cur_time_c = '{ms_hr:  current_time_ms_hr,  ls_hr:  current_time_ls_hr,
                         ms_min: current_time_ms_min, ls_min: current_time_ls_min};
  assign new_time_c = '{ms_hr:  new_alarm_ms_hr,     ls_hr:  new_alarm_ls_hr,
                         ms_min: new_alarm_ms_min,    ls_min: new_alarm_ls_min};

  // Load validation: legal 24-hour BCD time and an existing slot
  always_comb begin
    hr_ok_c = 1'b0;
    if (new_alarm_ms_hr < 4'd2)       hr_ok_c = (new_alarm_ls_hr <= 4'd9);
    else if (new_alarm_ms_hr == 4'd2) hr_ok_c = (new_alarm_ls_hr <= 4'd3);
    slot_ok_c    = (32'(load_slot) < NUM_ALARMS);
    load_valid_c = hr_ok_c && slot_ok_c &&
                   (new_alarm_ms_min <= 4'd5) && (new_alarm_ls_min <= 4'd9);
  end

  // Snooze target: current time + SNOOZE_MIN, done in binary then back to BCD
  always_comb begin
    cur_min_bin_c = MIN_W'(current_time_ms_min) * MIN_W'(10)
                  + MIN_W'(current_time_ls_min) + MIN_W'(SNOOZE_MIN);
    cur_hr_bin_c  = HR_W'(current_time_ms_hr) * HR_W'(10) + HR_W'(current_time_ls_hr);
    snz_min_bin_c = cur_min_bin_c;
    snz_hr_bin_c  = cur_hr_bin_c;
    if (cur_min_bin_c >= MIN_W'(60)) begin
      snz_min_bin_c = cur_min_bin_c - MIN_W'(60);
      snz_hr_bin_c  = cur_hr_bin_c + HR_W'(1);
    end
    if (snz_hr_bin_c >= HR_W'(24)) snz_hr_bin_c = snz_hr_bin_c - HR_W'(24);
    snz_calc_c.ms_hr  = 4'(snz_hr_bin_c / HR_W'(10));
    snz_calc_c.ls_hr  = 4'(snz_hr_bin_c % HR_W'(10));
    snz_calc_c.ms_min = 4'(snz_min_bin_c / MIN_W'(10));
    snz_calc_c.ls_min = 4'(snz_min_bin_c % MIN_W'(10));
  end

  // Snooze only counts when something is pending; it then overrides ack
  assign snooze_go_c = snooze && (|pend_q);
  assign ack_go_c    = alarm_ack && !snooze_go_c;

  // Per-slot next state: load > disable > snooze/ack, with a fire edge winning on pending
  always_comb begin
    time_d     = time_q;
    snz_time_d = snz_time_q;
    en_d       = en_q;
    pend_d     = pend_q;
    snz_act_d  = snz_act_q;
    mprev_d    = mprev_q;
    load_err_d = load_new_alarm && !load_valid_c;
    match_c    = '0;
    fire_c     = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      target_c[i] = snz_act_q[i] ? snz_time_q[i] : time_q[i];
      match_c[i]  = en_q[i] && (cur_time_c == target_c[i]);
      fire_c[i]   = match_c[i] && !mprev_q[i];
      mprev_d[i]  = match_c[i];
      if (load_new_alarm && load_valid_c && (load_slot == SLOT_W'(i))) begin
        time_d[i]    = new_time_c;
        en_d[i]      = 1'b1;
        pend_d[i]    = 1'b0;
        snz_act_d[i] = 1'b0;
        // Treat a load equal to the current time as already seen
        mprev_d[i]   = 1'b1;
      end else if (disable_alarm && (load_slot == SLOT_W'(i))) begin
        en_d[i]      = 1'b0;
        pend_d[i]    = 1'b0;
        snz_act_d[i] = 1'b0;
      end else begin
        if (snooze_go_c && pend_q[i]) begin
          snz_time_d[i] = snz_calc_c;
          snz_act_d[i]  = 1'b1;
          pend_d[i]     = 1'b0;
        end else if (ack_go_c) begin
          pend_d[i]     = 1'b0;
          snz_act_d[i]  = 1'b0;
        end
        if (fire_c[i]) begin
          pend_d[i] = 1'b1;
          // A fire from the snooze target ends that snooze
          if (snz_act_q[i] && !(snooze_go_c && pend_q[i])) snz_act_d[i] = 1'b0;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        time_q[i]     <= '0;
        snz_time_q[i] <= '0;
      end
      en_q       <= '0;
      pend_q     <= '0;
      snz_act_q  <= '0;
      mprev_q    <= '1;
      load_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        time_q[i]     <= time_d[i];
        snz_time_q[i] <= snz_time_d[i];
      end
      en_q       <= en_d;
      pend_q     <= pend_d;
      snz_act_q  <= snz_act_d;
      mprev_q    <= mprev_d;
      load_err_q <= load_err_d;
    end
  end

  // Readback mux; unpopulated slot indices read 00:00
  always_comb begin
    rd_time_c = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (rd_slot == SLOT_W'(i)) rd_time_c = time_q[i];
    end
  end

  assign alarm_time_ms_hr  = rd_time_c.ms_hr;
  assign alarm_time_ls_hr  = rd_time_c.ls_hr;
  assign alarm_time_ms_min = rd_time_c.ms_min;
  assign alarm_time_ls_min = rd_time_c.ls_min;
  assign alarm_enabled     = en_q;
  assign alarm_pending     = pend_q;
  assign alarm             = |pend_q;
  assign load_err          = load_err_q;

endmodule

// File: tb/tb_aclk_alarm_bank.sv
// ---------------------------------------------------------------------------
// tb_aclk_alarm_bank
// Directed bench for aclk_alarm_bank: loads, rejected loads, match/fire,
// acknowledge, snooze with midnight wrap, disable and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_aclk_alarm_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_new_alarm, disable_alarm, alarm_ack, snooze;
  logic [1:0] load_slot, rd_slot;
  logic [3:0] na_ms_hr, na_ls_hr, na_ms_min, na_ls_min;
  logic [3:0] ct_ms_hr, ct_ls_hr, ct_ms_min, ct_ls_min;
  logic [3:0] at_ms_hr, at_ls_hr, at_ms_min, at_ls_min;
  logic [3:0] alarm_enabled, alarm_pending;
  logic       alarm, load_err;
  logic [15:0] rd_time;

  int vectors = 0;
  int miscompares = 0;

  assign rd_time = {at_ms_hr, at_ls_hr, at_ms_min, at_ls_min};

  always #5 clock = ~clock;

  aclk_alarm_bank #(.NUM_ALARMS(4), .SLOT_W(2), .SNOOZE_MIN(9)) dut (
    .clock              (clock),
    .reset              (reset),
    .load_new_alarm     (load_new_alarm),
    .load_slot          (load_slot),
    .new_alarm_ms_hr    (na_ms_hr),
    .new_alarm_ls_hr    (na_ls_hr),
    .new_alarm_ms_min   (na_ms_min),
    .new_alarm_ls_min   (na_ls_min),
    .disable_alarm      (disable_alarm),
    .current_time_ms_hr (ct_ms_hr),
    .current_time_ls_hr (ct_ls_hr),
    .current_time_ms_min(ct_ms_min),
    .current_time_ls_min(ct_ls_min),
    .alarm_ack          (alarm_ack),
    .snooze             (snooze),
    .rd_slot            (rd_slot),
    .alarm_time_ms_hr   (at_ms_hr),
    .alarm_time_ls_hr   (at_ls_hr),
    .alarm_time_ms_min  (at_ms_min),
    .alarm_time_ls_min  (at_ls_min),
    .alarm_enabled      (alarm_enabled),
    .alarm_pending      (alarm_pending),
    .alarm              (alarm),
    .load_err           (load_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cur(input logic [15:0] t);
    {ct_ms_hr, ct_ls_hr, ct_ms_min, ct_ls_min} = t;
  endtask

  task automatic rd(input logic [1:0] s);
    rd_slot = s;
    #1;
  endtask

  task automatic load(input logic [1:0] s, input logic [15:0] t);
    load_slot = s;
    {na_ms_hr, na_ls_hr, na_ms_min, na_ls_min} = t;
    load_new_alarm = 1'b1;
    step();
    load_new_alarm = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load_new_alarm = 1'b0; disable_alarm = 1'b0; alarm_ack = 1'b0; snooze = 1'b0;
    load_slot = 2'd0; rd_slot = 2'd0;
    {na_ms_hr, na_ls_hr, na_ms_min, na_ls_min} = 16'h0000;
    set_cur(16'h0000);
    #1 reset = 1'b0;
    #1;
    chk("rst_pending",  16'(alarm_pending), 16'h0);
    chk("rst_enabled",  16'(alarm_enabled), 16'h0);
    chk("rst_alarm",    16'(alarm),         16'h0);
    chk("rst_load_err", 16'(load_err),      16'h0);
    chk("rst_time",     rd_time,            16'h0000);
    #1 reset = 1'b1;

    // 1: valid load
    load(2'd0, 16'h1230);
    rd(2'd0);
    chk("t1_time",    rd_time,            16'h1230);
    chk("t1_enabled", 16'(alarm_enabled), 16'h1);
    chk("t1_err",     16'(load_err),      16'h0);

    // 2: rejected loads, then a valid 19:59
    load(2'd1, 16'h2400);
    chk("t2_err_2400",  16'(load_err),      16'h1);
    chk("t2_en_2400",   16'(alarm_enabled), 16'h1);
    rd(2'd1);
    chk("t2_slot1",     rd_time,            16'h0000);
    step();
    chk("t2_err_clr1",  16'(load_err),      16'h0);
    load(2'd0, 16'h1260);
    chk("t2_err_1260",  16'(load_err),      16'h1);
    rd(2'd0);
    chk("t2_slot0",     rd_time,            16'h1230);
    step();
    chk("t2_err_clr2",  16'(load_err),      16'h0);
    load(2'd3, 16'h1959);
    chk("t2_err_1959",  16'(load_err),      16'h0);
    chk("t2_en_1959",   16'(alarm_enabled), 16'h9);

    // 3: fire, hold, acknowledge, no refire
    set_cur(16'h1044);
    load(2'd1, 16'h1045);
    chk("t3_enabled",   16'(alarm_enabled), 16'hB);
    step();
    chk("t3_pre_fire",  16'(alarm_pending), 16'h0);
    set_cur(16'h1045);
    step();
    chk("t3_fire",      16'(alarm_pending), 16'h2);
    chk("t3_alarm",     16'(alarm),         16'h1);
    repeat (50) step();
    chk("t3_hold",      16'(alarm_pending), 16'h2);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("t3_ack",       16'(alarm_pending), 16'h0);
    chk("t3_ack_alarm", 16'(alarm),         16'h0);
    repeat (5) step();
    chk("t3_no_refire", 16'(alarm_pending), 16'h0);

    // 4: snooze across midnight
    set_cur(16'h2354);
    load(2'd2, 16'h2355);
    step();
    set_cur(16'h2355);
    step();
    chk("t4_fire",      16'(alarm_pending), 16'h4);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t4_snoozed",   16'(alarm_pending), 16'h0);
    step();
    chk("t4_wait",      16'(alarm_pending), 16'h0);
    set_cur(16'h0003);
    step();
    chk("t4_0003",      16'(alarm_pending), 16'h0);
    set_cur(16'h0004);
    step();
    chk("t4_refire",    16'(alarm_pending), 16'h4);
    rd(2'd2);
    chk("t4_time_kept", rd_time,            16'h2355);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("t4_ack",       16'(alarm_pending), 16'h0);

    // 5: two slots at the same time, then disable one
    load(2'd0, 16'h0840);
    load(2'd3, 16'h0840);
    set_cur(16'h0839);
    step();
    set_cur(16'h0840);
    step();
    chk("t5_both",      16'(alarm_pending), 16'h9);
    chk("t5_alarm",     16'(alarm),         16'h1);
    load_slot = 2'd0;
    disable_alarm = 1'b1;
    step();
    disable_alarm = 1'b0;
    chk("t5_disable",   16'(alarm_pending), 16'h8);
    chk("t5_enabled",   16'(alarm_enabled), 16'hE);

    // 6: async reset with one slot snoozed and another pending
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t6_snoozed",   16'(alarm_pending), 16'h0);
    set_cur(16'h1044);
    step();
    set_cur(16'h1045);
    step();
    chk("t6_pending",   16'(alarm_pending), 16'h2);
    rd(2'd3);
    chk("t6_rd3",       rd_time,            16'h0840);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_pend",  16'(alarm_pending), 16'h0);
    chk("t6_rst_en",    16'(alarm_enabled), 16'h0);
    chk("t6_rst_alarm", 16'(alarm),         16'h0);
    chk("t6_rst_err",   16'(load_err),      16'h0);
    chk("t6_rst_time",  rd_time,            16'h0000);
    #1 reset = 1'b1;

    // Load equal to the current time must not fire
    set_cur(16'h0715);
    load(2'd0, 16'h0715);
    repeat (3) step();
    chk("eq_load_nofire", 16'(alarm_pending), 16'h0);
    chk("eq_load_en",     16'(alarm_enabled), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
